adau_i2s_receiver: RTL and testbench
====================================

# adau_i2s_receiver

Captures the ADAU codec's serial ADC stream (I2S, MSB-first, left channel while lrclk low) and presents complete stereo frames as parallel words over a valid/ready handshake. It sits beside `adau_interface` in the SoC clock domain. It consumes the `bclk`/`lrclk` pair that `adau_interface` drives to the codec, plus the codec's `adc_sdata` pin. It is the capture-side counterpart of the DAC serializer.

## Interface
- `SAMPLE_WIDTH`, default 24: bits captured per channel, MSB-first.
- `SLOT_WIDTH`, default 32: bclk periods per channel slot. Legal range is SAMPLE_WIDTH ≤ SLOT_WIDTH ≤ 64.
- `clk`  in  1: SoC clock (120 MHz). It must be ≥ 6× the bclk frequency.
- `reset_n`  in  1: asynchronous, active-low reset.
- `enable`  in  1: high = capture; low = abort capture and return to `WAIT_SYNC`.
- `bclk`  in  1: serial bit clock, asynchronous to `clk`.
- `lrclk`  in  1: word select, asynchronous to `clk`. 0 = left, 1 = right.
- `adc_sdata`  in  1: serial data from the codec ADC, asynchronous to `clk`.
- `audio_out`  out  2×SAMPLE_WIDTH: frame as {left, right}, raw two's complement.
- `audio_out_valid`  out  1: `audio_out` holds an unconsumed frame.
- `audio_out_ready`  in  1: consumer accepts the frame this cycle when valid is also high.
- `overflow`  out  1: sticky; a completed frame was dropped. Cleared only by reset.

## Operation
- **Input synchronisation.** `bclk`, `lrclk` and `adc_sdata` each pass through a 2-flop synchronizer. A third register on `bclk` provides rising-edge detect (`bclk_rise`).
- **Per-rise sampling.** On each `bclk_rise`:
  - the synchronized `lrclk` and `adc_sdata` are sampled together;
  - `lr_prev` holds the previous sampled `lrclk`.
- **Slot start.** When sampled `lrclk` ≠ `lr_prev`, the I2S one-bit delay applies:
  - the bit sampled on that rise is the LSB/pad of the previous slot and is discarded;
  - `bit_cnt` is cleared to 0;
  - the next rise carries the MSB.
- **Shifting.** Within a slot, the sampled bit is shifted into the channel shift register while `bit_cnt` < SAMPLE_WIDTH.
  - `bit_cnt` increments on every rise and saturates at SLOT_WIDTH−1.
  - Bits beyond SAMPLE_WIDTH are ignored.
- **State machine** (state register `st`):
  - `WAIT_SYNC`: nothing is captured. On a detected 1→0 `lrclk` transition, go to `LEFT`.
  - `LEFT`: shift into `left_sr`. On a 0→1 transition, go to `RIGHT`. A transition of the wrong polarity cannot occur.
  - `RIGHT`: shift into `right_sr`. When the rise with `bit_cnt` == SAMPLE_WIDTH−1 is shifted in, raise `frame_done` for 1 clk. On the next 1→0 transition, go to `LEFT`.
  - `enable` low in any state: go to `WAIT_SYNC` next clk. Shift registers are not cleared. A partially captured frame is discarded.
- **Output register.** On `frame_done`:
  - If `audio_out_valid` is 0, or `audio_out_valid && audio_out_ready` in the same cycle: load {`left_sr`, `right_sr`} and set valid.
  - Otherwise, drop the new frame, keep the old `audio_out`, and set `overflow`.
- **Consumption.** `audio_out_valid && audio_out_ready` without `frame_done` clears valid next clk.
- **Data stability.** `audio_out` is stable while valid is high and ready is low.
- **Reset values.** `audio_out` = 0, `audio_out_valid` = 0, `overflow` = 0, `st` = `WAIT_SYNC`, `bit_cnt` = 0, shift registers = 0, synchronizers = 0.

## Timing
- **Edge detect.** A `bclk` pin rising edge produces `bclk_rise` in the 3rd clk after it is registered (2 sync + 1 edge).
- **Sampling point.** Data and `lrclk` are sampled at the same synchronized edge. The codec changes `adc_sdata` on bclk falling edges, so each bclk half-period must span ≥ 3 clk.
- **Valid latency.** `audio_out_valid` rises exactly 1 clk after the `bclk_rise` that captures the right-channel bit SAMPLE_WIDTH−1. That is 4 clk after the corresponding pin edge.
- **Frame rate.** One frame is produced per `lrclk` period (48 kHz at 64 bclk/frame). The consumer has one full frame period (~2500 clk) to assert ready before an overflow occurs.
- **Handshake.** Acceptance is combinational on `audio_out_valid && audio_out_ready`. There is no combinational path from any input to `audio_out_valid`.
- **Reset and enable mid-frame.**
  - Asynchronous reset mid-frame: all outputs take their reset values immediately.
  - Reset released mid-slot: no capture until the first full left slot.
  - `enable` rising mid-frame: same behaviour, waits for the next 1→0 `lrclk` transition.

## Test plan
1. **Basic frame.** Reset, enable = 1, ready = 1. Drive I2S (bclk = clk/40, 32-bit slots) with L = 0x123456, R = 0xABCDEF. Expect one valid pulse with `audio_out` = 0x123456ABCDEF, arriving 4 clk after the bclk edge that carries the right LSB. `overflow` stays 0.
2. **Sync mid-frame.** Start the stream in the middle of a right slot. Expect no output for the partial frame. The first frame output is the next full L/R pair.
3. **Backpressure and overflow.** Hold ready = 0 across frames F1 (0x000001/0x000002) and F2 (0x7FFFFF/0x800000).
   - Expect `audio_out` to hold F1 and `overflow` = 1 after F2 completes.
   - Then ready = 1: expect valid to drop 1 clk later.
   - Expect F3 to be accepted normally.
4. **Simultaneous accept and new frame.** Assert ready in the exact clk of `frame_done` while holding an old frame. Expect the new frame loaded, valid to stay high, and `overflow` = 0.
5. **Enable mid-frame.** Deassert `enable` during the left slot, then reassert 10 clk later. Expect no frame from the interrupted pair. The next complete pair is output correctly.
6. **Reset mid-frame.** Assert `reset_n` = 0 while valid = 1 and mid-slot. Expect `audio_out` = 0 and valid = 0 immediately (asynchronous). After release, capture resumes from the next left slot.

Source files
------------

// File: rtl/adau_i2s_receiver_if.sv
// Frame output channel of the ADAU I2S receiver.
//   audio_out        {left, right} stereo frame, raw two's complement
//   audio_out_valid  audio_out holds an unconsumed frame
//   audio_out_ready  consumer accepts the frame when valid is also high
// master: the receiver (frame source); slave: the consumer.
interface adau_i2s_receiver_if #(
  parameter int unsigned SAMPLE_WIDTH = 24
);
  logic [2*SAMPLE_WIDTH-1:0] audio_out;
  logic                      audio_out_valid;
  logic                      audio_out_ready;

  modport master (
    output audio_out,
    output audio_out_valid,
    input  audio_out_ready
  );

  modport slave (
    input  audio_out,
    input  audio_out_valid,
    output audio_out_ready
  );
endinterface

// File: rtl/adau_i2s_receiver.sv
// ADAU codec ADC capture: deserialises the I2S stream (MSB-first, left while lrclk low,
// one-bit delay after each lrclk change) and presents complete stereo frames over a
// valid/ready channel.
//   clk        SoC clock, must be >= 6x the bclk frequency
//   reset_n    asynchronous active-low reset
//   enable     high = capture; low = abort and resynchronise
//   bclk       serial bit clock (asynchronous to clk)
//   lrclk      word select (asynchronous), 0 = left, 1 = right
//   adc_sdata  serial ADC data (asynchronous)
//   overflow   sticky: a completed frame was dropped because the previous one was unconsumed
//   audio      frame output channel (master side)
module adau_i2s_receiver #(
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned SLOT_WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       bclk,
  input  logic                       lrclk,
  input  logic                       adc_sdata,
  output logic                       overflow,
  adau_i2s_receiver_if.master        audio
);

  localparam int unsigned CntW = $clog2(SLOT_WIDTH + 1);
  localparam logic [CntW-1:0] CntMax    = CntW'(SLOT_WIDTH - 1);
  localparam logic [CntW-1:0] CntLast   = CntW'(SAMPLE_WIDTH - 1);
  localparam logic [CntW-1:0] CntSample = CntW'(SAMPLE_WIDTH);

  typedef enum logic [1:0] {
    StWaitSync,
    StLeft,
    StRight
  } st_e;

  // Synchronisers; bclk gets a third stage for rising-edge detection.
  logic [2:0] bclk_sync;
  logic [1:0] lr_sync;
  logic [1:0] sd_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      sd_sync   <= '0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], bclk};
      lr_sync   <= {lr_sync[0], lrclk};
      sd_sync   <= {sd_sync[0], adc_sdata};
    end
  end

  logic bclk_rise;
  logic lr_smp;
  logic sd_smp;

  // lrclk and data are taken from the same sync depth as the detected edge, so both
  // reflect the pin values just before the bclk rising edge.
  assign bclk_rise = bclk_sync[1] & ~bclk_sync[2];
  assign lr_smp    = lr_sync[1];
  assign sd_smp    = sd_sync[1];

  st_e                     st;
  logic [CntW-1:0]         bit_cnt;
  logic                    lr_prev;
  logic [SAMPLE_WIDTH-1:0] left_sr;
  logic [SAMPLE_WIDTH-1:0] right_sr;
  logic                    frame_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st         <= StWaitSync;
      bit_cnt    <= '0;
      lr_prev    <= 1'b0;
      left_sr    <= '0;
      right_sr   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // lr_prev tracks the line even while disabled, so re-enabling mid-frame still
      // needs a genuine 1->0 edge before capture resumes.
      if (bclk_rise) begin
        lr_prev <= lr_smp;
      end
      if (!enable) begin
        st <= StWaitSync;
      end else if (bclk_rise) begin
        if (lr_smp != lr_prev) begin
          // Slot boundary: this bit is the previous slot's LSB/pad and is dropped.
          bit_cnt <= '0;
          case (st)
            StWaitSync: if (!lr_smp) st <= StLeft;
            StLeft:     if (lr_smp)  st <= StRight;
            StRight:    if (!lr_smp) st <= StLeft;
            default:    st <= StWaitSync;
          endcase
        end else begin
          if (bit_cnt != CntMax) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (bit_cnt < CntSample) begin
            if (st == StLeft) begin
              left_sr <= {left_sr[SAMPLE_WIDTH-2:0], sd_smp};
            end else if (st == StRight) begin
              right_sr <= {right_sr[SAMPLE_WIDTH-2:0], sd_smp};
              if (bit_cnt == CntLast) begin
                frame_done <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // Output holding register. A frame completing in the same cycle the old one is
  // accepted replaces it without a valid gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      audio.audio_out       <= '0;
      audio.audio_out_valid <= 1'b0;
      overflow              <= 1'b0;
    end else if (frame_done) begin
      if (!audio.audio_out_valid || audio.audio_out_ready) begin
        audio.audio_out       <= {left_sr, right_sr};
        audio.audio_out_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (audio.audio_out_valid && audio.audio_out_ready) begin
      audio.audio_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adau_i2s_receiver.sv
// Bench for adau_i2s_receiver: drives directed I2S frames and checks delivered frames
// against a scoreboard queue, plus directed checks of reset, overflow and latency.
module tb_adau_i2s_receiver;

  localparam int SW   = 24;
  localparam int SLOT = 32;
  localparam int HALF = 20;  // bclk = clk / 40

  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  logic bclk;
  logic lrclk;
  logic adc_sdata;
  logic overflow;

  adau_i2s_receiver_if #(.SAMPLE_WIDTH(SW)) aif ();

  adau_i2s_receiver #(
    .SAMPLE_WIDTH(SW),
    .SLOT_WIDTH  (SLOT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .adc_sdata(adc_sdata),
    .overflow (overflow),
    .audio    (aif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int lsb_cyc = 0;
  bit ready_pulse = 1'b0;
  logic [2*SW-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // One bclk period: data/lrclk change with the falling edge, codec-style.
  task automatic drive_bit(input logic lr, input logic d, input bit lsb);
    bclk = 1'b0;
    lrclk = lr;
    adc_sdata = d;
    repeat (HALF) @(posedge clk);
    #1;
    bclk = 1'b1;
    if (lsb) lsb_cyc = cyc;
    if (lsb && ready_pulse) begin
      // frame_done is high in the cycle after the 3rd posedge following this edge.
      repeat (3) @(posedge clk);
      #1 aif.audio_out_ready = 1'b1;
      @(posedge clk);
      #1 aif.audio_out_ready = 1'b0;
      repeat (HALF - 4) @(posedge clk);
      #1;
    end else begin
      repeat (HALF) @(posedge clk);
      #1;
    end
  endtask

  // Slot of SLOT bclks; position 0 carries the one-bit-delay pad, 1..SW the sample MSB-first.
  task automatic send_slot(input logic lr, input logic [SW-1:0] data, input int first);
    logic d;
    for (int k = first; k < SLOT; k++) begin
      if (k >= 1 && k <= SW) d = data[SW-k];
      else d = 1'b0;
      drive_bit(lr, d, (lr == 1'b1) && (k == SW));
    end
  endtask

  task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
    exp_q.push_back({l, r});
    send_slot(1'b0, l, 0);
    send_slot(1'b1, r, 0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every accepted frame, checks valid-rise latency.
  logic valid_prev = 1'b0;
  always @(negedge clk) begin
    logic [2*SW-1:0] exp_f;
    if (aif.audio_out_valid && !valid_prev) begin
      check("valid_latency", 64'(cyc - lsb_cyc), 64'd4);
    end
    if (aif.audio_out_valid && aif.audio_out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got 0x%0h, expected no frame", aif.audio_out);
      end else begin
        exp_f = exp_q.pop_front();
        check("frame", 64'(aif.audio_out), 64'(exp_f));
      end
    end
    valid_prev = aif.audio_out_valid;
  end

  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    bclk = 1'b0;
    lrclk = 1'b0;
    adc_sdata = 1'b0;
    aif.audio_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 64'(aif.audio_out_valid), 64'd0);
    check("reset_audio", 64'(aif.audio_out), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    enable = 1'b1;
    aif.audio_out_ready = 1'b1;

    // Basic frame, preceded by a right slot so a 1->0 edge opens the left slot.
    send_slot(1'b1, 24'h0, 0);
    send_frame(24'h123456, 24'hABCDEF);
    check("t1_overflow", 64'(overflow), 64'd0);
    check("t1_drained", 64'(exp_q.size()), 64'd0);

    // Stream starts mid right slot: partial frame produces nothing.
    pulse_reset();
    send_slot(1'b1, 24'h0F0F0F, 12);
    send_frame(24'h111111, 24'h222222);
    check("t2_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: F1 held, F2 dropped with overflow, then drain and F3.
    aif.audio_out_ready = 1'b0;
    send_frame(24'h000001, 24'h000002);
    send_slot(1'b0, 24'h7FFFFF, 0);
    send_slot(1'b1, 24'h800000, 0);
    check("t3_hold_valid", 64'(aif.audio_out_valid), 64'd1);
    check("t3_hold_audio", 64'(aif.audio_out), 64'h000001000002);
    check("t3_overflow", 64'(overflow), 64'd1);
    aif.audio_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t3_valid_drop", 64'(aif.audio_out_valid), 64'd0);
    send_frame(24'h5A5A5A, 24'hA5A5A5);
    check("t3_overflow_sticky", 64'(overflow), 64'd1);
    check("t3_drained", 64'(exp_q.size()), 64'd0);

    // Accept in the exact frame_done cycle: new frame replaces old, no overflow.
    pulse_reset();
    aif.audio_out_ready = 1'b0;
    send_slot(1'b1, 24'h0, 0);
    send_frame(24'h0A0B0C, 24'h0D0E0F);
    ready_pulse = 1'b1;
    send_frame(24'h654321, 24'hFEDCBA);
    ready_pulse = 1'b0;
    check("t4_valid", 64'(aif.audio_out_valid), 64'd1);
    check("t4_audio", 64'(aif.audio_out), 64'h654321FEDCBA);
    check("t4_overflow", 64'(overflow), 64'd0);
    aif.audio_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t4_drained", 64'(exp_q.size()), 64'd0);

    // Enable dropped for 10 clk inside a left slot: that pair is discarded.
    fork
      send_slot(1'b0, 24'h333333, 0);
      begin
        repeat (200) @(posedge clk);
        #1 enable = 1'b0;
        repeat (10) @(posedge clk);
        #1 enable = 1'b1;
      end
    join
    send_slot(1'b1, 24'h444444, 0);
    send_frame(24'h13579B, 24'h2468AC);
    check("t5_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-slot while a frame is held.
    aif.audio_out_ready = 1'b0;
    send_frame(24'h7F0000, 24'h00FF80);
    check("t6_held", 64'(aif.audio_out_valid), 64'd1);
    fork
      send_slot(1'b0, 24'h555555, 0);
      begin
        repeat (300) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(aif.audio_out_valid), 64'd0);
        check("t6_rst_audio", 64'(aif.audio_out), 64'd0);
        check("t6_rst_overflow", 64'(overflow), 64'd0);
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1;
      end
    join
    aif.audio_out_ready = 1'b1;
    send_slot(1'b1, 24'h666666, 0);
    send_frame(24'h2468AC, 24'hFDB975);
    repeat (10) @(posedge clk);
    #1;
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
